// File: rtl/vga_objects_pkg.sv
// Shared types and constants for the VGA object drawing layers.
package vga_objects_pkg;

    typedef logic [7:0] rgb_t;

    // Color value an object drives for "inside my box but see-through".
    localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;

    localparam int DEFAULT_NUM_LAYERS = 4;

    // Per-frame collision tracker: has this frame seen an overlap yet?
    typedef enum logic {
        NO_HIT = 1'b0,
        HIT    = 1'b1
    } coll_state_t;

endpackage

// File: rtl/layer_priority_select.sv
// Combinational priority picker: lowest set bit of contribMask wins.
// Shared with HUD overlay muxes, so kept free of any color handling.
module layer_priority_select
    import vga_objects_pkg::*;
#(
    parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS,
    parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] contribMask,
    output logic                  winnerValid,
    output logic [IDX_W-1:0]      winnerIdx
);

    // Scan from the lowest-priority end so the last hit is the lowest index.
    always_comb begin
        winnerIdx   = '0;
        winnerValid = |contribMask;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (contribMask[i]) winnerIdx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/objects_priority_mux.sv
// Merges per-object drawing layers into one registered VGA color and
// tracks per-frame object overlaps for the game controller.
// Optional feature macro: COLLISION_DETECT_EN (collision FSM, frame
// accumulator and collision outputs). Without it only RGBout is built.
module objects_priority_mux
    import vga_objects_pkg::*;
#(
    parameter int   NUM_LAYERS       = DEFAULT_NUM_LAYERS,
    parameter rgb_t BACKGROUND_COLOR = 8'h00
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_LAYERS-1:0]   drawingRequest,
    input  logic [NUM_LAYERS*8-1:0] RGBin,
    input  logic                    startOfFrame,
    output rgb_t                    RGBout,
    output logic                    collisionPulse,
    output logic [NUM_LAYERS-1:0]   collisionLayers,
    output logic [NUM_LAYERS-1:0]   frameCollisions
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    rgb_t                  layer_rgb [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] contribMask;
    logic                  winnerValid;
    logic [IDX_W-1:0]      winnerIdx;
    rgb_t                  rgb_next;

    // A layer only counts if it asks to draw and is not see-through.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        assign layer_rgb[g]   = RGBin[8*g +: 8];
        assign contribMask[g] = drawingRequest[g] &&
                                (layer_rgb[g] != TRANSPARENT_ENCODING);
    end

    layer_priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_select (
        .contribMask (contribMask),
        .winnerValid (winnerValid),
        .winnerIdx   (winnerIdx)
    );

    // Winner color, or background when nothing is visible on this pixel.
    always_comb begin
        rgb_next = BACKGROUND_COLOR;
        if (winnerValid) rgb_next = layer_rgb[winnerIdx];
    end

    // Output color register; resets to black rather than the background.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) RGBout <= 8'h00;
        else         RGBout <= rgb_next;
    end

`ifdef COLLISION_DETECT_EN

    coll_state_t           state;
    logic [NUM_LAYERS-1:0] acc;
    logic                  is_coll;

    assign is_coll = ($countones(contribMask) >= 2);

    // Collision FSM plus frame accumulator. A collision on the
    // startOfFrame pixel belongs to the new frame, so it both pulses and
    // seeds the fresh accumulator instead of leaking into the old report.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= NO_HIT;
            acc             <= '0;
            collisionPulse  <= 1'b0;
            collisionLayers <= '0;
            frameCollisions <= '0;
        end else begin
            collisionLayers <= is_coll ? contribMask : '0;
            if (startOfFrame) begin
                frameCollisions <= acc;
                acc             <= is_coll ? contribMask : '0;
                state           <= is_coll ? HIT : NO_HIT;
                collisionPulse  <= is_coll;
            end else begin
                collisionPulse <= 1'b0;
                if (is_coll) begin
                    acc <= acc | contribMask;
                    if (state == NO_HIT) begin
                        state          <= HIT;
                        collisionPulse <= 1'b1;
                    end
                end
            end
        end
    end

`else

    // Frame markers have no consumer without collision tracking.
    logic unused_sof;
    assign unused_sof = startOfFrame;

    assign collisionPulse  = 1'b0;
    assign collisionLayers = '0;
    assign frameCollisions = '0;

`endif

endmodule

// File: doc/objects_priority_mux.md
# objects_priority_mux

Merges the drawing layer outputs of all on-screen objects (tanks, bullets, walls, score) into the single 8-bit RGB value sent to the VGA output stage. Each object presents a registered `drawingRequest`/`RGB` pair for the current pixel. This block selects the highest-priority non-transparent layer, registers the result, and tracks per-frame object overlaps (collisions) for the game-logic controller.

## Interface
Parameters:
- `NUM_LAYERS`, default 4: number of object layers; index 0 is the highest priority.
- `BACKGROUND_COLOR`, default 8'h00: color output when no layer contributes.

Ports:
- `clk`, in, 1: pixel clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `drawingRequest`, in, `NUM_LAYERS`: per-layer "pixel inside object" flags.
- `RGBin`, in, `NUM_LAYERS`×8 (packed, layer i at bits [8i+7:8i]): per-layer colors.
- `startOfFrame`, in, 1: one-cycle pulse aligned with the first pixel of a frame.
- `RGBout`, out, 8: merged pixel color.
- `collisionPulse`, out, 1: one-cycle pulse on the first collision pixel of a frame.
- `collisionLayers`, out, `NUM_LAYERS`: contributing-layer mask of the current pixel when it is a collision; 0 otherwise.
- `frameCollisions`, out, `NUM_LAYERS`: OR of all collision masks from the previous complete frame.

## Operation
- Layer i contributes when `drawingRequest[i]`=1 and `RGBin[i]` != 8'hFF (transparent encoding).
- `contribMask` is the per-layer contribute bits.
- Winner is the lowest contributing index. `RGBout` takes the winner's RGB, or `BACKGROUND_COLOR` when `contribMask`==0.
- A collision pixel is a pixel where `$countones(contribMask)` ≥ 2.
- Collision FSM states are `NO_HIT` and `HIT`:
  - `NO_HIT` → `HIT` on a collision pixel; `collisionPulse` fires on that pixel.
  - `HIT` stays `HIT` and does not pulse again.
  - Any state → `NO_HIT` on `startOfFrame`, unless that same pixel is a collision. In that case the state goes to `HIT` and the pulse fires, because the pixel belongs to the new frame.
- The frame accumulator ORs in `contribMask` on every collision pixel.
  - On `startOfFrame`, `frameCollisions` loads the accumulator value that excludes the current pixel.
  - The accumulator reloads with the current mask if the current pixel is a collision, otherwise with 0.
- Transparent pixels never count toward collisions, even when `drawingRequest`=1.

## Timing
- All outputs are registered, with a latency of 1 clk from inputs to `RGBout`, `collisionPulse` and `collisionLayers`. The object plus this mux therefore give 2 clk total pipeline delay.
- `frameCollisions` updates 1 clk after the `startOfFrame` input and is held for the entire frame.
- Reset values: `RGBout`=8'h00 (not `BACKGROUND_COLOR`), `collisionPulse`=0, `collisionLayers`=0, `frameCollisions`=0, accumulator=0, FSM=`NO_HIT`.
- An asynchronous reset mid-frame clears everything immediately. The first frame after reset reports collisions only from the first `startOfFrame` onward, so the partial frame is accumulated normally.
- There is no stall or handshake; the block accepts one pixel every clk.

## Configuration
- `COLLISION_DETECT_EN` defined: the FSM, accumulator and all collision outputs are implemented as above.
- `COLLISION_DETECT_EN` undefined:
  - `collisionPulse`, `collisionLayers` and `frameCollisions` are tied to 0.
  - No FSM and no accumulator registers are built.
  - `startOfFrame` is ignored.
  - `RGBout` behaviour is identical.

## Structure
- Package `vga_objects_pkg` holds:
  - `TRANSPARENT_ENCODING` = 8'hFF
  - `typedef logic [7:0] rgb_t`
  - the collision FSM state enum `coll_state_t`
  - `DEFAULT_NUM_LAYERS` = 4
- Sub-module `layer_priority_select` is combinational. It takes `contribMask` and outputs the `winnerValid` flag and the `winnerIdx` index (`$clog2(NUM_LAYERS)` bits), and is reused by future HUD overlays.

## Test plan
- Reset, and `resetN` low mid-stream: all outputs 0, `RGBout`=8'h00 while reset is asserted.
- No requests, `BACKGROUND_COLOR`=8'h00: `RGBout`=8'h00 with no collision.
- `drawingRequest`=4'b0011, `RGBin[0]`=8'hFF, `RGBin[1]`=8'h5b: 1 clk later `RGBout`=8'h5b, `collisionPulse`=0, `collisionLayers`=0.
- `drawingRequest`=4'b0110, `RGBin[1]`=8'h5b, `RGBin[2]`=8'h1c, after `startOfFrame`: 1 clk later `RGBout`=8'h5b, `collisionPulse`=1, `collisionLayers`=4'b0110.
- Collisions in the same frame with masks 4'b0110, then 4'b1001:
  - Only the first produces a pulse.
  - At the next `startOfFrame`, `frameCollisions`=4'b1111.
- `startOfFrame` coincident with collision mask 4'b0101, previous frame accumulator 4'b0011:
  - `frameCollisions`=4'b0011 and `collisionPulse`=1.
  - The following frame report equals 4'b0101 plus any later masks.
